// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - Shared fetch/decode constants and the instruction queue entry type
package arm_pipe_pkg;

    // ANDEQ r0,r0,r0: architecturally a no-op, used as the decode bubble
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - Synchronous FIFO with push/pop/clear; clear wins over push
module instr_queue
    import arm_pipe_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  T                           pushData,
    output T                           headData,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T              mem [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic          doPush;
    logic          doPop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign doPop    = pop & ~empty;
    // A full queue may still accept a push when the head leaves in the same cycle
    assign doPush   = push & (~full | doPop);
    assign headData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (reset | clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !(reset | clear)) mem[wrPtr] <= pushData;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && full && !pop && !clear));
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Fetch stage: PC, in-order imem requests, response queue and IF/ID register
module fetch_stage
    import arm_pipe_pkg::*;
#(
    parameter int          QDEPTH   = 2,
    parameter int          MAXOUT   = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCWrPendingF,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic        IReqF,
    output logic [31:0] IAddrF,
    input  logic        IReqReadyF,
    input  logic        IRespValid,
    input  logic [31:0] IRespData,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int OW = $clog2(MAXOUT + 1);
    localparam int SW = CW + OW;
    // Stale responses can pile up over several back-to-back redirects
    localparam int DW = 8;

    logic [31:0]   pc;
    logic [OW-1:0] outstanding;
    logic [DW-1:0] drop;

    logic          redir;
    logic [31:0]   redirTarget;
    logic          accept;
    logic          dropResp;
    logic          respAccept;

    fetch_entry_t  qPushData;
    fetch_entry_t  qHead;
    logic [CW-1:0] qCount;
    logic          qFull;
    logic          qEmpty;
    logic          qPop;

    logic [31:0]   addrHead;
    logic [CW-1:0] addrCount;
    logic          addrFull;
    logic          addrEmpty;

    assign redir       = BranchTakenE | PCSrcW;
    assign redirTarget = BranchTakenE ? ALUResultE : ResultW;

    assign IReqF  = ~reset & ~redir & ~PCWrPendingF
                  & ((SW'(outstanding) + SW'(qCount)) < SW'(QDEPTH))
                  & (outstanding < OW'(MAXOUT));
    assign IAddrF = pc;
    assign accept = IReqF & IReqReadyF;

    assign dropResp   = IRespValid & (drop != '0);
    assign respAccept = IRespValid & (drop == '0);

    assign qPushData = '{instr: IRespData, addr: addrHead};
    assign qPop      = ~reset & ~FlushD & ~StallD & ~qEmpty;

    instr_queue #(
        .DEPTH (QDEPTH),
        .T     (fetch_entry_t)
    ) u_instrQ (
        .clk      (clk),
        .reset    (reset),
        .clear    (redir),
        .push     (respAccept),
        .pop      (qPop),
        .pushData (qPushData),
        .headData (qHead),
        .count    (qCount),
        .full     (qFull),
        .empty    (qEmpty)
    );

    // Addresses of live requests, consumed in order as their responses return
    instr_queue #(
        .DEPTH (QDEPTH),
        .T     (logic [31:0])
    ) u_addrQ (
        .clk      (clk),
        .reset    (reset),
        .clear    (redir),
        .push     (accept),
        .pop      (respAccept),
        .pushData (IAddrF),
        .headData (addrHead),
        .count    (addrCount),
        .full     (addrFull),
        .empty    (addrEmpty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redir) begin
            pc <= redirTarget;
        end else if (accept) begin
            pc <= pc + 32'd4;
        end
    end

    // Redirect moves every live request into the drop count so the new epoch starts at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
            drop        <= '0;
        end else if (redir) begin
            outstanding <= '0;
            drop        <= drop + DW'(outstanding) - DW'(IRespValid);
        end else begin
            if (dropResp) drop <= drop - DW'(1);
            outstanding <= outstanding + OW'(accept) - OW'(respAccept);
        end
    end

    always_ff @(posedge clk) begin
        if (reset | FlushD) begin
            InstrD   <= NOP_INSTR;
            PCPlus8D <= '0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            if (!qEmpty) begin
                InstrD   <= qHead.instr;
                PCPlus8D <= qHead.addr + 32'd8;
                ValidD   <= 1'b1;
            end else begin
                InstrD   <= NOP_INSTR;
                PCPlus8D <= '0;
                ValidD   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(IRespValid && drop == '0 && outstanding == '0));
            assert (!(respAccept && !redir && qFull && !qPop));
            assert (qCount <= CW'(QDEPTH));
            assert (outstanding <= OW'(MAXOUT));
            assert (addrCount == CW'(outstanding));
            assert (!(accept && addrFull));
            assert (!(respAccept && addrEmpty));
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - Directed and randomized bench for fetch_stage with an imem model and epoch-based reference
module tb_fetch_stage;
    import arm_pipe_pkg::*;

    localparam int          QD  = 2;
    localparam int          MO  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, StallD, FlushD, PCWrPendingF, BranchTakenE, PCSrcW;
    logic [31:0] ALUResultE, ResultW;
    logic        IReqF, IReqReadyF, IRespValid, ValidD;
    logic [31:0] IAddrF, IRespData, InstrD, PCPlus8D;

    fetch_stage #(.QDEPTH(QD), .MAXOUT(MO), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD),
        .PCWrPendingF(PCWrPendingF), .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
        .PCSrcW(PCSrcW), .ResultW(ResultW), .IReqF(IReqF), .IAddrF(IAddrF),
        .IReqReadyF(IReqReadyF), .IRespValid(IRespValid), .IRespData(IRespData),
        .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } memReq_t;

    memReq_t      memQ[$];
    fetch_entry_t bufQ[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          curEpoch = 0;
    int          lat = 1;
    int          readyPct = 100;
    int          maxMem = 0;
    int          accCount = 0;
    logic [31:0] mPc;
    logic [31:0] expInstr, expPc8;
    logic        expValid;
    logic        dutAcc;
    logic [31:0] dutAddr;
    logic [31:0] held;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int inflight();
        int n = 0;
        foreach (memQ[i]) if (memQ[i].epoch == curEpoch) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive imem, check issue against the rules, advance the model, check IF/ID
    task automatic tick();
        logic         redir, expReq, respNow;
        memReq_t      r;
        fetch_entry_t e;
        respNow    = 1'b0;
        IRespValid = 1'b0;
        IRespData  = 32'h0;
        if (!reset && memQ.size() > 0 && memQ[0].due <= cyc) begin
            respNow    = 1'b1;
            IRespValid = 1'b1;
            IRespData  = memWord(memQ[0].addr);
        end
        IReqReadyF = ($urandom_range(99) < readyPct);
        #1;
        redir  = BranchTakenE | PCSrcW;
        expReq = !reset && !redir && !PCWrPendingF
               && (inflight() + bufQ.size() < QD) && (inflight() < MO);
        chk("IReqF", IReqF, expReq);
        if (expReq) chk("IAddrF", IAddrF, mPc);
        dutAcc  = IReqF && IReqReadyF;
        dutAddr = IAddrF;
        if (dutAcc) accCount++;

        if (reset || FlushD) begin
            expValid = 1'b0;
            expInstr = NOP_INSTR;
        end else if (!StallD) begin
            if (bufQ.size() > 0) begin
                e        = bufQ.pop_front();
                expValid = 1'b1;
                expInstr = e.instr;
                expPc8   = e.addr + 32'd8;
            end else begin
                expValid = 1'b0;
                expInstr = NOP_INSTR;
            end
        end

        if (respNow) begin
            r = memQ.pop_front();
            if (r.epoch == curEpoch) bufQ.push_back('{instr: memWord(r.addr), addr: r.addr});
        end
        if (dutAcc && !reset) begin
            memQ.push_back('{addr: IAddrF, due: cyc + lat, epoch: curEpoch});
            if (memQ.size() > maxMem) maxMem = memQ.size();
        end
        if (reset) begin
            memQ.delete();
            bufQ.delete();
            curEpoch++;
            mPc = RPC;
        end else if (redir) begin
            bufQ.delete();
            curEpoch++;
            mPc = BranchTakenE ? ALUResultE : ResultW;
        end else if (expReq && IReqReadyF) begin
            mPc = mPc + 32'd4;
        end

        @(posedge clk);
        cyc++;
        #1;
        chk("ValidD", ValidD, expValid);
        chk("InstrD", InstrD, expInstr);
        if (expValid) chk("PCPlus8D", PCPlus8D, expPc8);
    endtask

    task automatic waitAccept(input string tag);
        dutAcc = 1'b0;
        for (int i = 0; i < 40 && !dutAcc; i++) tick();
        chk(tag, dutAcc, 1'b1);
    endtask

    task automatic clearCtl();
        FlushD = 1'b0; StallD = 1'b0; PCWrPendingF = 1'b0;
        BranchTakenE = 1'b0; PCSrcW = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clearCtl();
        ALUResultE = '0; ResultW = '0;
        IReqReadyF = 1'b0; IRespValid = 1'b0; IRespData = '0;
        mPc = RPC; expValid = 1'b0; expInstr = NOP_INSTR; expPc8 = '0;
        @(posedge clk);
        #1;
        tick(); tick();
        chk("rst_instr", InstrD, NOP_INSTR);
        chk("rst_valid", ValidD, 1'b0);
        chk("rst_pc8", PCPlus8D, 32'h0);
        chk("rst_ireq", IReqF, 1'b0);

        reset = 1'b0;
        tick();
        chk("first_acc", dutAcc, 1'b1);
        chk("first_iaddr", dutAddr, 32'h0);
        tick(); tick();
        chk("first_valid", ValidD, 1'b1);
        chk("first_pc8", PCPlus8D, 32'h8);
        chk("first_instr", InstrD, memWord(32'h0));
        repeat (12) tick();

        lat = 3; maxMem = 0;
        repeat (20) tick();
        chk("max_outstanding", maxMem, MO);

        for (int i = 0; i < 20 && inflight() != 2; i++) tick();
        chk("two_outstanding", inflight(), 2);
        BranchTakenE = 1'b1; ALUResultE = 32'h100; FlushD = 1'b1;
        tick();
        chk("branch_flush", ValidD, 1'b0);
        clearCtl();
        waitAccept("branch_req_seen");
        chk("branch_target", dutAddr, 32'h100);
        for (int i = 0; i < 40 && !ValidD; i++) tick();
        chk("branch_first_pc8", PCPlus8D, 32'h108);

        PCSrcW = 1'b1; ResultW = 32'h200; BranchTakenE = 1'b1; ALUResultE = 32'h300; FlushD = 1'b1;
        tick();
        clearCtl();
        waitAccept("dual_req_seen");
        chk("dual_target", dutAddr, 32'h300);

        lat = 1;
        repeat (6) tick();
        StallD = 1'b1;
        held = InstrD;
        repeat (4) tick();
        chk("stall_hold", InstrD, held);
        chk("stall_ireq", IReqF, 1'b0);
        StallD = 1'b0;
        repeat (4) tick();
        StallD = 1'b1; FlushD = 1'b1;
        tick();
        chk("flush_stall", ValidD, 1'b0);
        clearCtl();

        repeat (3) tick();
        PCWrPendingF = 1'b1; accCount = 0;
        repeat (3) tick();
        chk("pend_noreq", accCount, 0);
        clearCtl();

        BranchTakenE = 1'b1; ALUResultE = 32'hFFFF_FFF8; FlushD = 1'b1;
        tick();
        clearCtl();
        waitAccept("wrap_req0");
        waitAccept("wrap_req1");
        waitAccept("wrap_req2");
        chk("wrap_addr", dutAddr, 32'h0);

        readyPct = 70;
        for (int i = 0; i < 400; i++) begin
            StallD       = ($urandom_range(99) < 20);
            PCWrPendingF = ($urandom_range(99) < 10);
            BranchTakenE = ($urandom_range(99) < 4);
            PCSrcW       = ($urandom_range(99) < 3);
            ALUResultE   = $urandom() & 32'hFFFF_FFFC;
            ResultW      = $urandom() & 32'hFFFF_FFFC;
            FlushD       = BranchTakenE | PCSrcW | ($urandom_range(99) < 5);
            lat          = $urandom_range(1, 4);
            tick();
        end
        clearCtl();
        readyPct = 100; lat = 1;

        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk("midrst_instr", InstrD, 32'h0);
        chk("midrst_valid", ValidD, 1'b0);
        reset = 1'b0;
        waitAccept("midrst_req_seen");
        chk("midrst_pc", dutAddr, RPC);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
